// File: rtl/seg_scan_display.sv
// seg_scan_display: 4-digit multiplexed 7-segment driver for the packed-BCD
// distance word. It scans one digit per slot and leaves a dead time at the
// start of each slot. Leading zeros can be blanked and a decimal point can be
// lit on a chosen digit. The data word is captured once per frame, so a
// digit can never change halfway through a frame.
module seg_scan_display #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEAD_CYCLES    = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic        sys_clk50m,
    input  logic        sys_rst,
    input  logic [15:0] data,
    input  logic        blank_lz,
    input  logic        dp_en,
    input  logic [1:0]  dp_sel,
    output logic [3:0]  seg_sel,
    output logic [7:0]  seg_led,
    output logic        frame_start
);

    localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD_CYCLES);
    localparam logic [3:0]    SEL_OFF  = SEL_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [7:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic          frame_start_q, frame_start_d;
    logic [3:0]    seg_sel_q, seg_sel_d;
    logic [7:0]    seg_led_q, seg_led_d;

    logic          frameLoad;
    logic [3:0]    digitVal;
    logic          upperZero;
    logic          blankDigit;
    logic          dpOn;
    logic          inDead;
    logic [6:0]    segRaw;
    logic [3:0]    selActive;
    logic [7:0]    ledActive;

    // Slot timing, frame snapshot, and the display value for the current (cnt, idx).
    // In the snapshot cycle, the decode path sees the value being loaded.
    // With zero dead time, slot 0 therefore still shows the new frame's data.
    always_comb begin
        cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        idx_d         = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        frameLoad     = (cnt_q == '0) && (idx_q == 2'd0);
        snap_d        = frameLoad ? data : snap_q;
        frame_start_d = frameLoad;

        digitVal = 4'h0;
        case (idx_q)
            2'd0: digitVal = snap_d[3:0];
            2'd1: digitVal = snap_d[7:4];
            2'd2: digitVal = snap_d[11:8];
            2'd3: digitVal = snap_d[15:12];
            default: digitVal = 4'h0;
        endcase

        upperZero = 1'b0;
        case (idx_q)
            2'd0: upperZero = 1'b0;
            2'd1: upperZero = (snap_d[15:4] == 12'h000);
            2'd2: upperZero = (snap_d[15:8] == 8'h00);
            2'd3: upperZero = (snap_d[15:12] == 4'h0);
            default: upperZero = 1'b0;
        endcase

        segRaw = 7'h40;
        case (digitVal)
            4'd0: segRaw = 7'h3F;
            4'd1: segRaw = 7'h06;
            4'd2: segRaw = 7'h5B;
            4'd3: segRaw = 7'h4F;
            4'd4: segRaw = 7'h66;
            4'd5: segRaw = 7'h6D;
            4'd6: segRaw = 7'h7D;
            4'd7: segRaw = 7'h07;
            4'd8: segRaw = 7'h7F;
            4'd9: segRaw = 7'h6F;
            default: segRaw = 7'h40;
        endcase

        blankDigit = blank_lz && (idx_q != 2'd0) && upperZero
                     && !(dp_en && (idx_q <= dp_sel));
        dpOn       = dp_en && (idx_q == dp_sel) && !blankDigit;
        inDead     = (cnt_q < DEAD_CNT);

        selActive = inDead ? 4'h0 : (4'b0001 << idx_q);
        ledActive = (inDead || blankDigit) ? 8'h00 : {dpOn, segRaw};

        seg_sel_d = SEL_ACTIVE_LOW ? ~selActive : selActive;
        seg_led_d = SEG_ACTIVE_LOW ? ~ledActive : ledActive;
    end

    // State and output registers. Reset forces the outputs inactive at once.
    always_ff @(posedge sys_clk50m or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            snap_q        <= 16'h0000;
            frame_start_q <= 1'b0;
            seg_sel_q     <= SEL_OFF;
            seg_led_q     <= SEG_OFF;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            frame_start_q <= frame_start_d;
            seg_sel_q     <= seg_sel_d;
            seg_led_q     <= seg_led_d;
        end
    end

    assign seg_sel     = seg_sel_q;
    assign seg_led     = seg_led_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: directed bench for the multiplexed 7-segment scanner.
// It uses SCAN_DIV=8 and DEAD_CYCLES=2. The active-low instance is the main
// device under test. A second, active-high instance shares the same inputs
// and covers the other output polarity.
module tb_seg_scan_display;

    logic        clk;
    logic        rstN;
    logic [15:0] data;
    logic        blankLz;
    logic        dpEn;
    logic [1:0]  dpSel;
    logic [3:0]  segSel,  segSelHi;
    logic [7:0]  segLed,  segLedHi;
    logic        frameStart, frameStartHi;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        bl;
        logic        de;
        logic [1:0]  ds;
        logic [31:0] digs;
    } vec_t;

    seg_scan_display #(
        .SCAN_DIV(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk50m(clk), .sys_rst(rstN), .data(data), .blank_lz(blankLz),
        .dp_en(dpEn), .dp_sel(dpSel), .seg_sel(segSel), .seg_led(segLed),
        .frame_start(frameStart)
    );

    seg_scan_display #(
        .SCAN_DIV(8), .DEAD_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)
    ) dutHi (
        .sys_clk50m(clk), .sys_rst(rstN), .data(data), .blank_lz(blankLz),
        .dp_en(dpEn), .dp_sel(dpSel), .seg_sel(segSelHi), .seg_led(segLedHi),
        .frame_start(frameStartHi)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Active-high select expected after posedge n following reset release.
    // The register holds the state from time index n-1.
    function automatic logic [3:0] expSelHi(int n);
        int t;
        t = n - 1;
        if ((t % 8) < 2) return 4'h0;
        return 4'b0001 << ((t / 8) % 4);
    endfunction

    // Active-high segments after posedge n. digs holds {d3,d2,d1,d0}; 00 means blank.
    function automatic logic [7:0] expLedHi(int n, logic [31:0] digs);
        int t;
        t = n - 1;
        if ((t % 8) < 2) return 8'h00;
        return digs[8 * ((t / 8) % 4) +: 8];
    endfunction

    // Pulse reset low for two cycles; release it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // Outputs and frame_start held inactive while reset is asserted
    task automatic test_reset();
        rstN    = 1'b0;
        data    = 16'h1234;
        blankLz = 1'b0;
        dpEn    = 1'b0;
        dpSel   = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (segSel !== 4'hF) begin
            errors++;
            $display("[TB] FAIL reset_sel got %h exp %h", segSel, 4'hF);
        end
        checks++;
        if (segLed !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_led got %h exp %h", segLed, 8'hFF);
        end
        checks++;
        if (frameStart !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_fs got %b exp 0", frameStart);
        end
        checks++;
        if (segSelHi !== 4'h0 || segLedHi !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_hi got %h/%h exp 0/00", segSelHi, segLedHi);
        end
        rstN = 1'b1;
    endtask

    // One full frame per vector: encoding, blanking, decimal point and both polarities
    task automatic test_digits();
        vec_t vecs[10];
        vecs[0] = '{16'h1234, 1'b0, 1'b0, 2'd0, 32'h065B4F66};
        vecs[1] = '{16'h0042, 1'b1, 1'b0, 2'd0, 32'h0000665B};
        vecs[2] = '{16'h0005, 1'b1, 1'b1, 2'd1, 32'h0000BF6D};
        vecs[3] = '{16'h0A00, 1'b1, 1'b0, 2'd0, 32'h00403F3F};
        vecs[4] = '{16'h0A00, 1'b0, 1'b0, 2'd0, 32'h3F403F3F};
        vecs[5] = '{16'h5678, 1'b0, 1'b0, 2'd0, 32'h6D7D077F};
        vecs[6] = '{16'h9CE0, 1'b0, 1'b1, 2'd3, 32'hEF40403F};
        vecs[7] = '{16'h0000, 1'b1, 1'b1, 2'd0, 32'h000000BF};
        vecs[8] = '{16'h0000, 1'b1, 1'b0, 2'd0, 32'h0000003F};
        vecs[9] = '{16'h0100, 1'b1, 1'b1, 2'd3, 32'hBF063F3F};
        for (int v = 0; v < 10; v++) begin
            data    = vecs[v].d;
            blankLz = vecs[v].bl;
            dpEn    = vecs[v].de;
            dpSel   = vecs[v].ds;
            do_reset();
            for (int n = 1; n <= 32; n++) begin
                @(negedge clk);
                checks++;
                if (segSel !== ~expSelHi(n)) begin
                    errors++;
                    $display("[TB] FAIL digits_sel vec=%0d n=%0d got %h exp %h",
                             v, n, segSel, ~expSelHi(n));
                end
                checks++;
                if (segLed !== ~expLedHi(n, vecs[v].digs)) begin
                    errors++;
                    $display("[TB] FAIL digits_led vec=%0d n=%0d got %h exp %h",
                             v, n, segLed, ~expLedHi(n, vecs[v].digs));
                end
                checks++;
                if (segSelHi !== expSelHi(n) || segLedHi !== expLedHi(n, vecs[v].digs)) begin
                    errors++;
                    $display("[TB] FAIL digits_hi vec=%0d n=%0d got %h/%h exp %h/%h",
                             v, n, segSelHi, segLedHi, expSelHi(n), expLedHi(n, vecs[v].digs));
                end
            end
        end
    endtask

    // A data change mid-frame waits for the next frame; frame_start pulses once per 32 cycles
    task automatic test_back_to_back();
        logic [31:0] digs;
        int          pulses;
        pulses  = 0;
        data    = 16'h1111;
        blankLz = 1'b0;
        dpEn    = 1'b0;
        dpSel   = 2'd0;
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            digs = (n <= 32) ? 32'h06060606 : 32'h5B5B5B5B;
            checks++;
            if (segSel !== ~expSelHi(n)) begin
                errors++;
                $display("[TB] FAIL b2b_sel n=%0d got %h exp %h", n, segSel, ~expSelHi(n));
            end
            checks++;
            if (segLed !== ~expLedHi(n, digs)) begin
                errors++;
                $display("[TB] FAIL b2b_led n=%0d got %h exp %h", n, segLed, ~expLedHi(n, digs));
            end
            checks++;
            if (frameStart !== (((n - 1) % 32) == 0)) begin
                errors++;
                $display("[TB] FAIL b2b_fs n=%0d got %b exp %b",
                         n, frameStart, (((n - 1) % 32) == 0));
            end
            if (frameStart === 1'b1) pulses++;
            if (n == 17) data = 16'h2222;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("[TB] FAIL b2b_pulses got %0d exp 2", pulses);
        end
    endtask

    // Asynchronous reset in the middle of slot 2, then a clean restart with a fresh snapshot
    task automatic test_reset_mid_scan();
        logic [31:0] digs;
        data    = 16'h1234;
        blankLz = 1'b0;
        dpEn    = 1'b0;
        dpSel   = 2'd0;
        do_reset();
        repeat (21) @(negedge clk);
        checks++;
        if (segSel !== 4'hB || segLed !== 8'hA4) begin
            errors++;
            $display("[TB] FAIL midrst_pre got %h/%h exp B/A4", segSel, segLed);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (segSel !== 4'hF || segLed !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL midrst_async got %h/%h exp F/FF", segSel, segLed);
        end
        checks++;
        if (segSelHi !== 4'h0 || segLedHi !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_async_hi got %h/%h exp 0/00", segSelHi, segLedHi);
        end
        data = 16'h4321;
        @(negedge clk);
        rstN = 1'b1;
        digs = 32'h664F5B06;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            checks++;
            if (segSel !== ~expSelHi(n)) begin
                errors++;
                $display("[TB] FAIL midrst_sel n=%0d got %h exp %h", n, segSel, ~expSelHi(n));
            end
            checks++;
            if (segLed !== ~expLedHi(n, digs)) begin
                errors++;
                $display("[TB] FAIL midrst_led n=%0d got %h exp %h", n, segLed, ~expLedHi(n, digs));
            end
        end
    endtask

    // Run the scenarios in order and print the summary line
    initial begin
        rstN    = 1'b0;
        data    = 16'h0000;
        blankLz = 1'b0;
        dpEn    = 1'b0;
        dpSel   = 2'd0;
        test_reset();
        test_digits();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
